// File: rtl/sc_arb_pkg.sv
// ============================================================================
// Module      : sc_arb_pkg
// Description : Shared types, constants and helpers for the short-circuit
//               compare/select arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sc_arb_pkg;

  // Sequencer states: idle, first compare term, second compare term.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TERM0 = 2'd1,
    TERM1 = 2'd2
  } state_t;

  localparam int SHORT_CNT_W = 16;
  localparam logic [SHORT_CNT_W-1:0] SHORT_CNT_MAX = '1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SHORT_CNT_W-1:0] sat_inc(input logic [SHORT_CNT_W-1:0] v);
    return (v == SHORT_CNT_MAX) ? v : v + SHORT_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches from last+1
//               upward (mod NUM_REQ) and returns the first active request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  // Walk the requesters in rotated priority order; first hit wins.
  always_comb begin
    int cand;
    cand     = 0;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any        = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/short_circuit_arbiter.sv
// ============================================================================
// Module      : short_circuit_arbiter
// Description : Round-robin arbiter sharing one equality-compare/select unit
//               among NUM_REQ requesters. Evaluates lhs0==rhs0 and, when
//               requested and the first term is true, lhs1==rhs1 (short-
//               circuit AND), then returns cond ? then_val : else_val.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module short_circuit_arbiter
  import sc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        two_term,
  input  logic [NUM_REQ*DATA_W-1:0] lhs0,
  input  logic [NUM_REQ*DATA_W-1:0] rhs0,
  input  logic [NUM_REQ*DATA_W-1:0] lhs1,
  input  logic [NUM_REQ*DATA_W-1:0] rhs1,
  input  logic [NUM_REQ*DATA_W-1:0] then_val,
  input  logic [NUM_REQ*DATA_W-1:0] else_val,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         result,
  output logic                      cond,
  output logic                      busy,
  output logic [SHORT_CNT_W-1:0]    short_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  // Picker outputs
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // Winner operands selected from the flattened input buses
  logic [DATA_W-1:0] sel_lhs0, sel_rhs0, sel_lhs1, sel_rhs1, sel_then, sel_else;

  // Captured request context
  state_t             state_q;
  logic [IDX_W-1:0]   last_q;
  logic [DATA_W-1:0]  lhs0_q, rhs0_q, lhs1_q, rhs1_q, then_q, else_q;
  logic               two_q;

  // Registered outputs
  logic [NUM_REQ-1:0]     gnt_q, done_q;
  logic [DATA_W-1:0]      result_q;
  logic                   cond_q;
  logic [SHORT_CNT_W-1:0] short_cnt_q, short_cnt_d;

  logic               c0, c1;
  logic [NUM_REQ-1:0] owner_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Route the round-robin winner's operands toward the capture registers.
  always_comb begin
    sel_lhs0 = lhs0[pick_idx*DATA_W +: DATA_W];
    sel_rhs0 = rhs0[pick_idx*DATA_W +: DATA_W];
    sel_lhs1 = lhs1[pick_idx*DATA_W +: DATA_W];
    sel_rhs1 = rhs1[pick_idx*DATA_W +: DATA_W];
    sel_then = then_val[pick_idx*DATA_W +: DATA_W];
    sel_else = else_val[pick_idx*DATA_W +: DATA_W];
  end

  // The single shared comparator pair, plus the done vector for the owner.
  always_comb begin
    c0           = (lhs0_q == rhs0_q);
    c1           = (lhs1_q == rhs1_q);
    owner_onehot = NUM_REQ'(1) << last_q;
  end

  // Counter advances only when the second term is skipped by a false first term.
  always_comb begin
    short_cnt_d = short_cnt_q;
    if (state_q == TERM0 && two_q && !c0) begin
      short_cnt_d = sat_inc(short_cnt_q);
    end
  end

  // Sequencer: capture in IDLE, evaluate term0/term1, then publish the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= LAST_RST;
      lhs0_q   <= '0;
      rhs0_q   <= '0;
      lhs1_q   <= '0;
      rhs1_q   <= '0;
      then_q   <= '0;
      else_q   <= '0;
      two_q    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      cond_q   <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            lhs0_q  <= sel_lhs0;
            rhs0_q  <= sel_rhs0;
            lhs1_q  <= sel_lhs1;
            rhs1_q  <= sel_rhs1;
            then_q  <= sel_then;
            else_q  <= sel_else;
            two_q   <= two_term[pick_idx];
            last_q  <= pick_idx;
            gnt_q   <= pick;
            state_q <= TERM0;
          end
        end
        TERM0: begin
          if (!two_q || !c0) begin
            cond_q   <= c0;
            result_q <= c0 ? then_q : else_q;
            done_q   <= owner_onehot;
            state_q  <= IDLE;
          end else begin
            state_q <= TERM1;
          end
        end
        TERM1: begin
          cond_q   <= c1;
          result_q <= c1 ? then_q : else_q;
          done_q   <= owner_onehot;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating short-circuit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      short_cnt_q <= '0;
    end else begin
      short_cnt_q <= short_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign result      = result_q;
  assign cond        = cond_q;
  assign busy        = (state_q != IDLE);
  assign short_count = short_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_short_circuit_arbiter.sv
// ============================================================================
// Module      : tb_short_circuit_arbiter
// Description : Directed, table-driven bench for short_circuit_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_short_circuit_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_r, two_r;
  logic [N*W-1:0]   lhs0_r, rhs0_r, lhs1_r, rhs1_r, then_r, else_r;
  logic [N-1:0]     gnt, done;
  logic [W-1:0]     result;
  logic             cond, busy;
  logic [15:0]      short_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] sc_exp = 16'd0;

  short_circuit_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req_r),
    .two_term    (two_r),
    .lhs0        (lhs0_r),
    .rhs0        (rhs0_r),
    .lhs1        (lhs1_r),
    .rhs1        (rhs1_r),
    .then_val    (then_r),
    .else_val    (else_r),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .cond        (cond),
    .busy        (busy),
    .short_count (short_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          tt;
    logic [31:0] l0, r0, l1, r1, tv, ev;
    bit          exp_cond;
    int          exp_lat;
    bit          exp_short;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_req(input int i, input bit tt, input logic [31:0] l0, input logic [31:0] r0,
                          input logic [31:0] l1, input logic [31:0] r1,
                          input logic [31:0] tv, input logic [31:0] ev);
    req_r[i]          = 1'b1;
    two_r[i]          = tt;
    lhs0_r[i*W +: W]  = l0;
    rhs0_r[i*W +: W]  = r0;
    lhs1_r[i*W +: W]  = l1;
    rhs1_r[i*W +: W]  = r1;
    then_r[i*W +: W]  = tv;
    else_r[i*W +: W]  = ev;
  endtask

  task automatic clear_all();
    req_r  = '0; two_r  = '0;
    lhs0_r = '0; rhs0_r = '0; lhs1_r = '0; rhs1_r = '0;
    then_r = '0; else_r = '0;
  endtask

  // Wait until gnt or done (sel) is nonzero, bounded; returns cycles waited.
  task automatic wait_sig(input bit sel_done, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (((sel_done ? done : gnt) == '0) && c < 10);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c;
    logic [31:0] exp_res;
    exp_res = v.exp_cond ? v.tv : v.ev;
    @(negedge clk);
    clear_all();
    load_req(v.idx, v.tt, v.l0, v.r0, v.l1, v.r1, v.tv, v.ev);
    wait_sig(1'b0, c);
    chk({tag, "_gnt"}, 64'(gnt), 64'(1) << v.idx);
    chk({tag, "_gnt_lat"}, 64'(c), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    req_r = '0;
    wait_sig(1'b1, c);
    if (v.exp_short && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
    chk({tag, "_done"}, 64'(done), 64'(1) << v.idx);
    chk({tag, "_done_lat"}, 64'(c), 64'(v.exp_lat));
    chk({tag, "_cond"}, 64'(cond), 64'(v.exp_cond));
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_short"}, 64'(short_count), 64'(sc_exp));
    chk({tag, "_gnt_off"}, 64'(gnt), 64'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    int c;
    int order[5];
    vec_t sv;

    // idx tt  l0            r0            l1  r1  then  else  cond lat short
    vecs[0] = '{1, 1'b0, 32'd4,         32'd4,         32'd0, 32'd0, 32'd25, 32'd15, 1'b1, 1, 1'b0};
    vecs[1] = '{0, 1'b1, 32'd291,       32'd4,         32'd0, 32'd0, 32'd77, 32'd99, 1'b0, 1, 1'b1};
    vecs[2] = '{2, 1'b1, 32'd5,         32'd5,         32'd7, 32'd8, 32'd33, 32'd44, 1'b0, 2, 1'b0};
    vecs[3] = '{3, 1'b1, 32'd5,         32'd5,         32'd9, 32'd9, 32'd55, 32'd66, 1'b1, 2, 1'b0};
    vecs[4] = '{1, 1'b0, 32'd1,         32'd2,         32'd0, 32'd0, 32'd11, 32'd12, 1'b0, 1, 1'b0};
    vecs[5] = '{2, 1'b1, 32'h8000_0000, 32'h0,         32'd3, 32'd3, 32'd21, 32'd22, 1'b0, 1, 1'b1};
    vecs[6] = '{0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hA5A5_5A5A, 32'd1, 1'b1, 1, 1'b0};

    clear_all();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cond", 64'(cond), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_short", 64'(short_count), 64'd0);
    reset = 1'b0;

    // All requesters held: expect 0,1,2,3,0 with one grant per operation.
    order = '{0, 1, 2, 3, 0};
    @(negedge clk);
    for (int i = 0; i < N; i++) load_req(i, 1'b0, i, i, 0, 0, 100 + i, 200 + i);
    for (int k = 0; k < 5; k++) begin
      wait_sig(1'b0, c);
      chk("rr_gnt", 64'(gnt), 64'(1) << order[k]);
      chk("rr_gap", 64'(c), 64'd1);
      if (k == 4) req_r = '0;
      @(negedge clk);
      chk("rr_done", 64'(done), 64'(1) << order[k]);
      chk("rr_result", 64'(result), 64'(100 + order[k]));
    end
    @(negedge clk);
    chk("rr_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while requester 2 sits in TERM1; requester 0 also waiting.
    @(negedge clk);
    clear_all();
    load_req(2, 1'b1, 32'd6, 32'd6, 32'd8, 32'd8, 32'h222, 32'h333);
    wait_sig(1'b0, c);
    chk("t1_gnt", 64'(gnt), 64'b0100);
    @(negedge clk);
    chk("t1_inflight", 64'(busy), 64'd1);
    load_req(0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 32'hAA, 32'hBB);
    reset = 1'b1;
    #1;
    chk("t1_rst_busy", 64'(busy), 64'd0);
    chk("t1_rst_result", 64'(result), 64'd0);
    chk("t1_rst_cond", 64'(cond), 64'd0);
    chk("t1_rst_short", 64'(short_count), 64'd0);
    sc_exp = 16'd0;
    repeat (2) @(negedge clk);
    chk("t1_no_done", 64'(done), 64'd0);
    reset = 1'b0;
    wait_sig(1'b0, c);
    chk("t1_prio0", 64'(gnt), 64'b0001);
    req_r[0] = 1'b0;
    @(negedge clk);
    chk("t1_done0", 64'(done), 64'b0001);
    chk("t1_res0", 64'(result), 64'hAA);
    wait_sig(1'b0, c);
    chk("t1_regnt2", 64'(gnt), 64'b0100);
    req_r = '0;
    wait_sig(1'b1, c);
    chk("t1_done2", 64'(done), 64'b0100);
    chk("t1_lat2", 64'(c), 64'd2);
    chk("t1_res2", 64'(result), 64'h222);
    chk("t1_cond2", 64'(cond), 64'd1);

    // Saturation: preload counter just below max, then two short-circuits.
    @(negedge clk);
    force dut.short_cnt_q = 16'hFFFE;
    #1;
    release dut.short_cnt_q;
    sc_exp = 16'hFFFE;
    chk("sat_preload", 64'(short_count), 64'hFFFE);
    sv = vecs[1];
    run_vec(sv, "sat1");
    chk("sat_max", 64'(short_count), 64'hFFFF);
    run_vec(sv, "sat2");
    chk("sat_hold", 64'(short_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
